// File: rtl/csc_col_stream.sv
// csc_col_stream: streams the tridiagonal MAT_RANK x MAT_RANK matrix built from
// latched coefficients in CSC order (column by column, rows ascending), one
// nonzero per valid/ready beat.
module csc_col_stream #(
    parameter int MAT_RANK = 256,
    parameter int IDX_W    = $clog2(MAT_RANK),
    parameter int NNZ_W    = $clog2(3*MAT_RANK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      z0,
    input  logic [31:0]      z1,
    input  logic [31:0]      s_val_r,
    input  logic [31:0]      s_val_i,
    input  logic [31:0]      a0_val_r,
    input  logic [31:0]      a0_val_i,
    input  logic [31:0]      a1_val_r,
    input  logic [31:0]      a1_val_i,
    input  logic             val_vld,
    input  logic             start,
    output logic             busy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic [31:0]      out_val_r,
    output logic [31:0]      out_val_i,
    output logic [NNZ_W-1:0] out_nnz,
    output logic             out_last_col,
    output logic             out_last,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_RANK - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state;
    logic [31:0]      z0_q, z1_q, s_r_q, s_i_q, a0_r_q, a0_i_q, a1_r_q, a1_i_q;
    logic [IDX_W-1:0] col_cnt;
    logic [1:0]       slot_cnt;

    logic [IDX_W-1:0] nxt_row;
    logic [31:0]      nxt_val_r, nxt_val_i;
    logic             nxt_last_col, nxt_last;

    // Next beat from (column, slot): column 0 starts on the diagonal, every
    // other column starts on the super-diagonal entry one row above.
    always_comb begin
        nxt_row   = '0;
        nxt_val_r = '0;
        nxt_val_i = '0;
        if (col_cnt == '0) begin
            nxt_row = IDX_W'(slot_cnt);
            if (slot_cnt == 2'd0) begin
                nxt_val_r = z0_q;
                nxt_val_i = '0;
            end else begin
                nxt_val_r = a0_r_q;
                nxt_val_i = a0_i_q;
            end
        end else begin
            nxt_row = col_cnt - IDX_W'(1) + IDX_W'(slot_cnt);
            if (slot_cnt == 2'd0) begin
                nxt_val_r = a1_r_q;
                nxt_val_i = a1_i_q;
            end else if (slot_cnt == 2'd1) begin
                nxt_val_r = (col_cnt == LAST_IDX) ? z1_q : s_r_q;
                nxt_val_i = (col_cnt == LAST_IDX) ? 32'd0 : s_i_q;
            end else begin
                nxt_val_r = a0_r_q;
                nxt_val_i = a0_i_q;
            end
        end
        nxt_last_col = (slot_cnt == 2'd2) ||
                       ((slot_cnt == 2'd1) && ((col_cnt == '0) || (col_cnt == LAST_IDX)));
        nxt_last     = nxt_last_col && (col_cnt == LAST_IDX);
    end

    // Sequencer: coefficient latch in IDLE, beat generation with skid-free hold in EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            z0_q         <= '0;
            z1_q         <= '0;
            s_r_q        <= '0;
            s_i_q        <= '0;
            a0_r_q       <= '0;
            a0_i_q       <= '0;
            a1_r_q       <= '0;
            a1_i_q       <= '0;
            col_cnt      <= '0;
            slot_cnt     <= '0;
            busy         <= 1'b0;
            out_vld      <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            out_val_r    <= '0;
            out_val_i    <= '0;
            out_nnz      <= '0;
            out_last_col <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (val_vld) begin
                        z0_q   <= z0;
                        z1_q   <= z1;
                        s_r_q  <= s_val_r;
                        s_i_q  <= s_val_i;
                        a0_r_q <= a0_val_r;
                        a0_i_q <= a0_val_i;
                        a1_r_q <= a1_val_r;
                        a1_i_q <= a1_val_i;
                    end
                    if (start) begin
                        state    <= EMIT;
                        busy     <= 1'b1;
                        col_cnt  <= '0;
                        slot_cnt <= '0;
                    end
                end
                EMIT: begin
                    if (!out_vld || out_rdy) begin
                        if (out_vld && out_last) begin
                            // Final beat accepted: clear the output fields and hand back.
                            state        <= IDLE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            out_vld      <= 1'b0;
                            out_row      <= '0;
                            out_col      <= '0;
                            out_val_r    <= '0;
                            out_val_i    <= '0;
                            out_nnz      <= '0;
                            out_last_col <= 1'b0;
                            out_last     <= 1'b0;
                        end else begin
                            out_vld      <= 1'b1;
                            out_row      <= nxt_row;
                            out_col      <= col_cnt;
                            out_val_r    <= nxt_val_r;
                            out_val_i    <= nxt_val_i;
                            out_nnz      <= out_vld ? out_nnz + NNZ_W'(1) : '0;
                            out_last_col <= nxt_last_col;
                            out_last     <= nxt_last;
                            if (nxt_last_col) begin
                                slot_cnt <= '0;
                                col_cnt  <= (col_cnt == LAST_IDX) ? '0 : col_cnt + IDX_W'(1);
                            end else begin
                                slot_cnt <= slot_cnt + 2'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/csc_col_stream.md
Name: csc_col_stream

Overview:
- Downstream consumer of the coefficient latch stage.
- Takes the latched tridiagonal coefficients (s, a0, a1 complex; z0, z1 real boundary terms) and streams the MAT_RANK x MAT_RANK matrix in CSC order: column by column, rows ascending.
- Output is one nonzero per beat over a valid/ready handshake, for the downstream solver/memory writer.

Parameters:
- MAT_RANK, 256, matrix dimension N. Legal range is N >= 2.
- IDX_W, $clog2(MAT_RANK), row/column index width.
- NNZ_W, $clog2(3*MAT_RANK), nonzero counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- z0  in  32  real value of diagonal element (0,0).
- z1  in  32  real value of diagonal element (N-1,N-1).
- s_val_r / s_val_i  in  32 each  interior diagonal value, real/imag.
- a0_val_r / a0_val_i  in  32 each  sub-diagonal value (row j+1, col j), real/imag.
- a1_val_r / a1_val_i  in  32 each  super-diagonal value (row j-1, col j), real/imag.
- val_vld  in  1  latch all coefficient inputs this cycle.
- start  in  1  single-cycle pulse that begins a stream.
- busy  out  1  high from the cycle after an accepted start through the final handshake.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts the beat.
- out_row  out  IDX_W  row index of the beat.
- out_col  out  IDX_W  column index of the beat.
- out_val_r / out_val_i  out  32 each  element value, real/imag.
- out_nnz  out  NNZ_W  running nonzero index, 0-based.
- out_last_col  out  1  last nonzero of the current column.
- out_last  out  1  last nonzero of the matrix.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset: all outputs are 0, all coefficient registers are 0, FSM is in IDLE.
- Coefficient latch:
  - When val_vld=1 in IDLE, all eight 32-bit inputs are registered.
  - val_vld is ignored while busy; coefficients stay frozen for the whole stream.
- FSM has two states, IDLE and EMIT.
  - IDLE -> EMIT on start=1. start is ignored in EMIT.
  - If val_vld and start arrive in the same IDLE cycle, the new coefficients are latched and used by that stream.
- Latency: start sampled at edge t; out_vld=1 with the first beat after edge t+1.
- Handshake:
  - A beat transfers on out_vld & out_rdy.
  - All out_* fields are registered and held stable while out_vld & !out_rdy.
  - out_vld never drops without a transfer.
  - With out_rdy tied high, throughput is 1 beat/cycle and there are no bubbles.
- Ordering:
  - Column j emits row j-1 (a1) if j>0, then row j (diagonal), then row j+1 (a0) if j<N-1.
  - Diagonal value is {z0, 0} for j=0, {z1, 0} for j=N-1, and {s_val_r, s_val_i} otherwise.
  - Column 0 and column N-1 each have 2 nonzeros; interior columns have 3.
  - Total nonzeros = 3N-2 (766 for N=256).
- Counters:
  - Column counter wraps 0..N-1.
  - A 2-bit in-column slot counter resets per column.
  - out_nnz increments per transfer, from 0 to 3N-3.
- Flags:
  - out_last_col=1 on the final beat of each column.
  - out_last=1 only on row N-1, col N-1, coincident with out_last_col.
- Completion:
  - On the transfer of the out_last beat, next cycle out_vld=0, busy=0, done=1 for exactly one cycle, FSM returns to IDLE.
  - A start in the done cycle is accepted.
- Reset mid-stream: outputs and counters clear immediately (asynchronous). No done pulse; the partial stream is discarded. Coefficient registers also clear.
- Arithmetic: no arithmetic on values, pass-through only. Indices are unsigned.

Test Plan:
- Reset: assert rst mid-run -> out_vld=0, busy=0, done=0, out_nnz=0 within the same cycle; no beats until the next start.
- N=4, out_rdy=1, after latching z0=5, z1=9, s=(1,2), a0=(3,4), a1=(6,7), start -> 10 beats (row,col,val):
  - (0,0,5+0i), (1,0,3+4i)
  - (0,1,6+7i), (1,1,1+2i), (2,1,3+4i)
  - (1,2,6+7i), (2,2,1+2i), (3,2,3+4i)
  - (2,3,6+7i), (3,3,9+0i)
  - out_last_col on beats 1, 4, 7, 9; out_last on beat 9; done one cycle later; 10 consecutive cycles.
- Backpressure, N=4: out_rdy toggles 1,0,0,1,... -> fields are constant during stalls; same 10-beat sequence; out_nnz 0..9 without gaps.
- Busy lockout: val_vld with s=(8,8) and start pulses during EMIT -> stream values unchanged; exactly 10 beats; one done pulse.
- Default N=256, out_rdy=1 -> 766 beats; beat 765 is (255,255,z1) with out_last=1; done at cycle 767 after start.
- Back-to-back: start in the done cycle -> second stream begins the next cycle with out_nnz=0.
